// File: rtl/spart.sv
// spart: bus-side responder and serial engine for the SPART.
//
// Answers the processor-side driver's chip-select transactions. It holds a
// programmable baud divisor and derives a 16x oversampling tick from it. It
// serializes transmit bytes onto txd and deserializes rxd into a receive
// buffer.
//
// Ports:
//   clk      system clock (100 MHz)
//   rst      asynchronous, active-low reset
//   iocs     chip select, a transaction is active while high
//   iorw     1 = read (SPART drives databus), 0 = write (driver drives databus)
//   ioaddr   00 data (RX buffer / TX), 01 status, 10 DBL, 11 DBH
//   databus  bidirectional 8-bit bus, driven only during reads
//   rda      receive data available
//   tbr      transmit buffer ready (transmitter idle)
//   txd      serial out, idle high
//   rxd      serial in, asynchronous to clk
module spart #(
    parameter logic [15:0] RST_DIV = 16'h028B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        wr_en;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [15:0] divisor;
    logic [15:0] baud_cnt;
    logic        tick;

    tx_state_t   tx_state;
    logic [7:0]  tx_shift;
    logic [3:0]  tx_tcnt;
    logic [2:0]  tx_bit;

    logic        rx_meta;
    logic        rx_s;
    rx_state_t   rx_state;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_buf;
    logic [3:0]  rx_tcnt;
    logic [2:0]  rx_bit;

    assign wr_en = iocs & ~iorw;
    assign rd_en = iocs & iorw;

    // Divisors of 0 and 1 both collapse to a tick on every cycle.
    assign tick = (divisor <= 16'd1) || (baud_cnt == divisor - 16'd1);

    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            2'b00:   rd_data = rx_buf;
            2'b01:   rd_data = {6'b0, tbr, rda};
            2'b10:   rd_data = divisor[7:0];
            default: rd_data = divisor[15:8];
        endcase
    end

    assign databus = rd_en ? rd_data : 8'bzzzz_zzzz;

    // Divisor registers and baud counter; any divisor write restarts the
    // counter so the new rate applies cleanly from the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor  <= RST_DIV;
            baud_cnt <= 16'd0;
        end else begin
            if (wr_en && ioaddr == 2'b11) divisor[15:8] <= databus;
            if (wr_en && ioaddr == 2'b10) divisor[7:0]  <= databus;
            if (wr_en && ioaddr[1])
                baud_cnt <= 16'd0;
            else if (tick)
                baud_cnt <= 16'd0;
            else
                baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // Transmitter. A load parks in TX_WAIT until the next tick so the start
    // bit begins on a tick boundary; every bit then lasts 16 ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= 8'h00;
            tx_tcnt  <= 4'd0;
            tx_bit   <= 3'd0;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (wr_en && ioaddr == 2'b00) begin
                        tx_shift <= databus;
                        tbr      <= 1'b0;
                        tx_state <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tick) begin
                        txd      <= 1'b0;
                        tx_tcnt  <= 4'd0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_tcnt == 4'd15) begin
                            tx_tcnt  <= 4'd0;
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= 3'd0;
                            tx_state <= TX_DATA;
                        end else begin
                            tx_tcnt <= tx_tcnt + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_tcnt == 4'd15) begin
                            tx_tcnt <= 4'd0;
                            if (tx_bit == 3'd7) begin
                                txd      <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                txd      <= tx_shift[0];
                                tx_shift <= {1'b0, tx_shift[7:1]};
                                tx_bit   <= tx_bit + 3'd1;
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (tx_tcnt == 4'd15) begin
                            tx_tcnt  <= 4'd0;
                            tbr      <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_tcnt <= tx_tcnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous rxd pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // Receiver. Sampling is centred by checking the start bit 8 ticks in and
    // then every 16 ticks. A good stop bit assigned after the read-clear, so a
    // same-cycle buffer load wins over a data read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rx_tcnt  <= 4'd0;
            rx_bit   <= 3'd0;
            rda      <= 1'b0;
        end else begin
            if (rd_en && ioaddr == 2'b00) rda <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (tick && !rx_s) begin
                        rx_tcnt  <= 4'd0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt  <= 4'd0;
                            rx_bit   <= 3'd0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt  <= 4'd0;
                            rx_shift <= {rx_s, rx_shift[7:1]};
                            if (rx_bit == 3'd7)
                                rx_state <= RX_STOP;
                            else
                                rx_bit <= rx_bit + 3'd1;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt  <= 4'd0;
                            rx_state <= RX_IDLE;
                            if (rx_s) begin
                                rx_buf <= rx_shift;
                                rda    <= 1'b1;
                            end
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart.sv
// tb_spart: directed and randomized bench for spart.
// Inputs are driven on the falling clock edge and outputs sampled there too,
// half a cycle away from the active rising edge. Expected serial frames and
// receive results come from a byte-level model of the UART protocol.
module tb_spart;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       drv_en;
    logic [7:0] drv_data;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_buf;
    logic       model_rda;
    logic [7:0] rd;
    logic [7:0] rnd;

    assign databus = drv_en ? drv_data : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    // Hard stop in case some wait loop never terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic cs, input logic rw, input logic [1:0] addr,
                                 input logic en, input logic [7:0] data);
        iocs     = cs;
        iorw     = rw;
        ioaddr   = addr;
        drv_en   = en;
        drv_data = data;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, addr, 1'b1, data);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, addr, 1'b0, 8'h00);
        #1 data = databus;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        if (addr == 2'b00) model_rda = 1'b0;
    endtask

    // Drives one frame on rxd: start bit, 8 data bits LSB first, stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            cycles(BIT);
        end
        rxd = 1'b1;
        if (stop_bit) begin
            model_buf = data;
            model_rda = 1'b1;
        end
    endtask

    task automatic wait_rda();
        int n;
        n = 0;
        while (rda !== 1'b1 && n < 50) begin
            cycles(1);
            n++;
        end
    endtask

    // Writes a byte held for three cycles, then checks every bit at its centre.
    task automatic check_tx_frame(input logic [7:0] data);
        logic [9:0] frame;
        logic       found;
        int         fall_k;
        int         cur_k;
        int         n;
        frame  = {1'b1, data, 1'b0};
        found  = 1'b0;
        fall_k = 0;
        cur_k  = 0;
        checkOutput("tbr_ready", 16'(tbr), 16'd1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, data);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            cur_k = k;
            if (k == 1) checkOutput("tbr_drop", 16'(tbr), 16'd0);
            if (k == 3) begin
                checkOutput("tbr_held_low", 16'(tbr), 16'd0);
                applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
            end
            if (!found && txd == 1'b0) begin
                found  = 1'b1;
                fall_k = k;
            end
            if (found && k >= 3) break;
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        checkOutput("tx_start_seen", 16'(found), 16'd1);
        if (found) begin
            cycles(BIT / 2 - (cur_k - fall_k));
            for (int i = 0; i < 10; i++) begin
                checkOutput($sformatf("tx_bit%0d_of_%h", i, data), 16'(txd), 16'(frame[i]));
                if (i < 9) cycles(BIT);
            end
            checkOutput("tbr_busy_in_stop", 16'(tbr), 16'd0);
            n = 0;
            while (tbr !== 1'b1 && n < BIT) begin
                cycles(1);
                n++;
            end
            checkOutput("tbr_rise", 16'(tbr), 16'd1);
            checkOutput("txd_idle", 16'(txd), 16'd1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        rxd       = 1'b1;
        model_buf = 8'h00;
        model_rda = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        cycles(3);
        checkOutput("rst_txd", 16'(txd), 16'd1);
        checkOutput("rst_tbr", 16'(tbr), 16'd1);
        checkOutput("rst_rda", 16'(rda), 16'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 8'hAA);
        #1 checkOutput("rst_bus_released", 16'(databus), 16'h00AA);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        bus_read(2'b01, rd);
        checkOutput("status_after_rst", 16'(rd), 16'h0002);
        bus_read(2'b11, rd);
        checkOutput("dbh_after_rst", 16'(rd), 16'h0002);
        bus_read(2'b10, rd);
        checkOutput("dbl_after_rst", 16'(rd), 16'h008B);

        bus_write(2'b11, 8'h00);
        bus_write(2'b10, 8'(DIV));
        bus_read(2'b10, rd);
        checkOutput("dbl_written", 16'(rd), 16'(DIV));
        bus_read(2'b11, rd);
        checkOutput("dbh_written", 16'(rd), 16'h0000);

        // Driver owns the bus during writes; a status write is ignored.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 8'h55);
        #1 checkOutput("bus_write_no_contention", 16'(databus), 16'h0055);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 8'h55);
        #1 checkOutput("bus_idle_no_contention", 16'(databus), 16'h0055);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        bus_read(2'b01, rd);
        checkOutput("status_write_ignored", 16'(rd), 16'h0002);

        check_tx_frame(8'hA5);
        for (int t = 0; t < 3; t++) begin
            rnd = 8'($urandom_range(255));
            check_tx_frame(rnd);
        end

        cycles(20);
        send_frame(8'h3C, 1'b1);
        wait_rda();
        checkOutput("rx_rda_3c", 16'(rda), 16'(model_rda));
        bus_read(2'b00, rd);
        checkOutput("rx_data_3c", 16'(rd), 16'(model_buf));
        checkOutput("rx_rda_cleared", 16'(rda), 16'(model_rda));

        for (int t = 0; t < 2; t++) begin
            cycles(20);
            rnd = 8'($urandom_range(255));
            send_frame(rnd, 1'b1);
            wait_rda();
            checkOutput("rx_rda_rand", 16'(rda), 16'(model_rda));
            bus_read(2'b01, rd);
            checkOutput("status_rda_set", 16'(rd), 16'h0003);
            bus_read(2'b00, rd);
            checkOutput("rx_data_rand", 16'(rd), 16'(model_buf));
            checkOutput("rx_rda_rand_cleared", 16'(rda), 16'(model_rda));
        end

        cycles(20);
        rxd = 1'b0;
        cycles(20);
        rxd = 1'b1;
        cycles(BIT * 11);
        checkOutput("false_start_no_rda", 16'(rda), 16'(model_rda));

        rnd = 8'($urandom_range(255));
        send_frame(rnd, 1'b0);
        cycles(BIT * 2);
        checkOutput("framing_err_no_rda", 16'(rda), 16'(model_rda));
        bus_read(2'b00, rd);
        checkOutput("framing_err_buf_kept", 16'(rd), 16'(model_buf));

        cycles(20);
        send_frame(8'h11, 1'b1);
        cycles(20);
        send_frame(8'h22, 1'b1);
        wait_rda();
        checkOutput("overrun_rda", 16'(rda), 16'(model_rda));
        bus_read(2'b00, rd);
        checkOutput("overrun_data", 16'(rd), 16'(model_buf));
        checkOutput("overrun_rda_cleared", 16'(rda), 16'(model_rda));

        // Reset in the middle of a transmit frame with a byte waiting.
        cycles(20);
        rnd = 8'($urandom_range(255));
        send_frame(rnd, 1'b1);
        wait_rda();
        checkOutput("pre_reset_rda", 16'(rda), 16'(model_rda));
        rnd = 8'($urandom_range(255));
        bus_write(2'b00, rnd);
        cycles(100);
        checkOutput("pre_reset_tbr_busy", 16'(tbr), 16'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        model_buf = 8'h00;
        model_rda = 1'b0;
        #1;
        checkOutput("midframe_rst_txd", 16'(txd), 16'd1);
        checkOutput("midframe_rst_tbr", 16'(tbr), 16'd1);
        checkOutput("midframe_rst_rda", 16'(rda), 16'(model_rda));
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 8'hAA);
        #1 checkOutput("midframe_rst_bus", 16'(databus), 16'h00AA);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
        cycles(2);
        rst = 1'b1;
        bus_read(2'b01, rd);
        checkOutput("midframe_status", 16'(rd), 16'h0002);
        bus_read(2'b11, rd);
        checkOutput("midframe_dbh", 16'(rd), 16'h0002);
        bus_read(2'b10, rd);
        checkOutput("midframe_dbl", 16'(rd), 16'h008B);
        bus_read(2'b00, rd);
        checkOutput("midframe_rxbuf", 16'(rd), 16'(model_buf));
        checkOutput("midframe_txd_idle", 16'(txd), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spart.md
# spart

Bus-side responder and serial engine for the SPART: it answers the processor-side driver's `iocs`/`iorw`/`ioaddr`/`databus` transactions. It holds the programmable baud divisor, generates a 16x oversampling baud tick, serializes transmit bytes onto `txd` and deserializes `rxd` into a receive buffer. It reports buffer state on `rda`/`tbr`. It sits between the driver and the board UART pins.

## Interface
- `RST_DIV`, 16'h028B, divisor loaded at reset (9600 baud at 100 MHz, 16x oversampling).
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `iocs`  in  1  chip select; a transaction is active while high.
- `iorw`  in  1  1 = read (SPART drives bus), 0 = write (driver drives bus).
- `ioaddr`  in  2  00 = data (RX buffer on read, TX on write), 01 = status (read only), 10 = DBL, 11 = DBH.
- `databus`  inout  8  driven by the SPART only when `iocs`=1 and `iorw`=1; otherwise Z.
- `rda`  out  1  receive data available.
- `tbr`  out  1  transmit buffer ready (transmitter idle).
- `txd`  out  1  serial out, idle high.
- `rxd`  in  1  serial in, asynchronous.

## Operation
- Writes occur on each rising edge with `iocs`=1 and `iorw`=0:
  - 11 loads divisor[15:8] and 10 loads divisor[7:0]. Either write clears the baud counter.
  - 00 with `tbr`=1 loads the TX shift register and clears `tbr`. 00 with `tbr`=0 is ignored.
  - A write to 01 is ignored.
- Reads are combinational while `iocs`=1 and `iorw`=1:
  - 00 returns the RX buffer.
  - 01 returns {6'b0, tbr, rda}.
  - 10 and 11 return the divisor bytes.
- A read of 00 clears `rda` at the next edge, whether or not the read is repeated.
- Baud generator: a 16-bit up-counter. It pulses `tick` for one cycle when count == divisor-1, then restarts at 0. A divisor of 0 or 1 gives a tick every cycle.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE. `txd`=1 in IDLE.
  - A load waits for the next `tick`, then drives the start bit.
  - Each bit lasts 16 ticks.
  - `tbr` returns to 1 on the tick that ends the stop bit.
- RX path: `rxd` passes through a 2-flop synchronizer first.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized low on a tick enters START. The tick counter restarts there.
  - START: at tick 8 the FSM re-samples. If `rxd` is high it treats this as a false start and returns to IDLE; otherwise it goes to DATA.
  - DATA: 8 samples, each 16 ticks after the previous one, shifted LSB first.
  - STOP: sampled 16 ticks after the last data sample. A high sample loads the RX buffer and sets `rda`. A low sample is a framing error: the byte is discarded and `rda` is unchanged. Either way the FSM returns to IDLE.
- Overrun: a new good byte overwrites the RX buffer and `rda` stays 1.
- A buffer load and a data read in the same cycle: the load wins and `rda`=1.
- Reset (async, any time) forces:
  - Both FSMs to IDLE and counters to 0.
  - divisor = `RST_DIV`, RX buffer = 0.
  - `txd`=1, `tbr`=1, `rda`=0, `databus`=Z.
  - Any frame in progress is aborted.

## Timing
- `tbr` falls at the edge that accepts the TX write. The driver's multi-cycle WRITE state therefore loads only once.
- `rda` rises one edge after the stop-bit sample tick and falls one edge after the first data-read edge.
- Read data is valid in the same cycle the address is presented, with zero wait states.
- TX latency from the write edge to the `txd` falling edge is at most `divisor` cycles (the wait for the next tick).
- A frame is 160 ticks.
- RX latency from the start edge on `rxd` to `rda` is about 152 ticks, plus 2–3 cycles for the synchronizer and sampling.
- The divisor takes effect from the cycle after its write.

## Test plan
- Reset: assert `rst`=0 mid-frame -> `txd`=1, `tbr`=1, `rda`=0, `databus`=Z. A status read returns 8'h02 and reads of 11/10 return 8'h02/8'h8B.
- Divisor and TX: write DBH=00, DBL=04, then data 8'hA5 held for 3 cycles.
  - `tbr` must drop once.
  - `txd` must carry 0,1,0,1,0,0,1,0,1,1 with each bit 64 cycles.
  - `tbr` must rise after the stop bit.
- RX: at divisor 4, drive the frame for 8'h3C on `rxd` -> `rda`=1, a read of 00 returns 8'h3C, and `rda`=0 one edge later.
- False start and framing error:
  - A 20-cycle low glitch on `rxd` -> no `rda`.
  - A frame with stop bit 0 -> `rda` stays 0.
- Overrun: receive 8'h11 then 8'h22 without reading -> `rda`=1 and a read returns 8'h22.
- Bus contention: while `iorw`=0, `databus` is never driven by the SPART. Drive 8'h55 externally and check no X on the bus.
